// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO, per-frame latched format
// (5..DATA_WIDTH data bits, parity, 1/2 stop bits), integer baud divider and break.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic [3:0]                  data_len,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop_bits,
    input  logic                        send_break,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic                        tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP1     = 3'd4;
    localparam logic [2:0] S_STOP2     = 3'd5;
    localparam logic [2:0] S_BREAK     = 3'd6;
    localparam logic [2:0] S_BREAK_END = 3'd7;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [2:0]            r_state;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [DIV_WIDTH-1:0]  r_baud;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_len;
    logic [3:0]            r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_tx;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DIV_WIDTH-1:0]  w_baud_eff;
    logic [3:0]            w_len_eff;
    logic                  w_par_raw;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_frame_end;
    logic                  w_brk_start;

    // Write handshake: a word is accepted on any rising edge where tx_valid and
    // tx_ready are both high; tx_ready depends only on the registered count.
    assign tx_ready   = (r_count < CW'(FIFO_DEPTH));
    assign w_push     = tx_valid && tx_ready;
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_count = r_count;

    assign w_baud_eff = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
    assign w_len_eff  = ((data_len < 4'd5) || (int'(data_len) > DATA_WIDTH))
                        ? 4'(DATA_WIDTH) : data_len;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            w_mask[i] = (i < int'(w_len_eff));
    end

    assign w_par_raw   = ^(w_head & w_mask);
    assign w_bit_end   = (r_div_cnt == '0);
    assign w_last_stop = (r_state == S_STOP2) || ((r_state == S_STOP1) && !r_stop2);
    assign w_frame_end = w_last_stop && w_bit_end;
    assign w_brk_start = (r_state == S_IDLE) && send_break;
    // A pending break blocks the pop, so it wins both at idle and at frame end.
    assign w_pop       = !w_empty && !send_break && ((r_state == S_IDLE) || w_frame_end);

    assign uart_tx = r_tx;
    assign tx_busy = (r_state != S_IDLE);
    assign tx_done = w_frame_end;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_div_cnt <= '0;
            r_baud    <= DIV_WIDTH'(2);
            r_shift   <= '0;
            r_len     <= 4'(DATA_WIDTH);
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            // Divider holds at zero once expired, which is what lets BREAK
            // stretch past its minimum bit time until send_break drops.
            if (!w_bit_end)
                r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);

            if (w_pop) begin
                r_shift  <= w_head;
                r_len    <= w_len_eff;
                r_par_en <= (parity_mode != 2'd0);
                r_stop2  <= stop_bits;
                case (parity_mode)
                    2'd1:    r_par_bit <= w_par_raw;
                    2'd2:    r_par_bit <= ~w_par_raw;
                    default: r_par_bit <= 1'b1;
                endcase
            end
            if (w_pop || w_brk_start)
                r_baud <= w_baud_eff;

            if (w_pop) begin
                r_state   <= S_START;
                r_tx      <= 1'b0;
                r_div_cnt <= w_baud_eff - DIV_WIDTH'(1);
            end else if (w_brk_start) begin
                r_state   <= S_BREAK;
                r_tx      <= 1'b0;
                r_div_cnt <= w_baud_eff - DIV_WIDTH'(1);
            end else if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= 4'd1;
                        r_div_cnt <= r_baud - DIV_WIDTH'(1);
                    end
                    S_DATA: begin
                        r_div_cnt <= r_baud - DIV_WIDTH'(1);
                        if (r_bit_cnt >= r_len) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                            r_tx    <= r_par_en ? r_par_bit : 1'b1;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        r_state   <= S_STOP1;
                        r_tx      <= 1'b1;
                        r_div_cnt <= r_baud - DIV_WIDTH'(1);
                    end
                    S_STOP1: begin
                        r_tx <= 1'b1;
                        if (r_stop2) begin
                            r_state   <= S_STOP2;
                            r_div_cnt <= r_baud - DIV_WIDTH'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_STOP2: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    S_BREAK: begin
                        if (!send_break) begin
                            r_state   <= S_BREAK_END;
                            r_tx      <= 1'b1;
                            r_div_cnt <= r_baud - DIV_WIDTH'(1);
                        end
                    end
                    S_BREAK_END: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-of-line-levels model checked every cycle,
// plus directed frames with hand-computed timing and bit values.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DIVW-1:0] baud_div;
    logic [3:0]      data_len;
    logic [1:0]      parity_mode;
    logic            stop_bits;
    logic            send_break;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [4:0]      fifo_count;
    logic            uart_tx;
    logic            tx_busy;
    logic            tx_done;

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_len(data_len),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .send_break(send_break),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the FIFO is a queue of words and the current frame is a queue of
    // line levels, one entry per clock cycle.
    logic [DW-1:0] exp_q[$];
    bit            m_line[$];
    int            m_mode = 0;   // 0 idle, 1 frame, 2 break, 3 break end
    int            m_brk_cyc;
    int            m_brk_baud;
    int            m_end_left;

    function automatic int eff_baud(input int b);
        return (b < 2) ? 2 : b;
    endfunction

    function automatic int eff_len(input int l);
        return (l < 5 || l > DW) ? DW : l;
    endfunction

    task automatic build_frame(input logic [DW-1:0] w);
        int b, len, ones;
        b = eff_baud(int'(baud_div));
        len = eff_len(int'(data_len));
        ones = 0;
        for (int k = 0; k < b; k++) m_line.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            ones += int'(w[i]);
            for (int k = 0; k < b; k++) m_line.push_back(w[i]);
        end
        if (parity_mode != 2'd0) begin
            bit p;
            p = (parity_mode == 2'd1) ? bit'(ones % 2) :
                (parity_mode == 2'd2) ? bit'(1 - ones % 2) : 1'b1;
            for (int k = 0; k < b; k++) m_line.push_back(p);
        end
        for (int k = 0; k < b * (stop_bits ? 2 : 1); k++) m_line.push_back(1'b1);
        m_mode = 1;
    endtask

    task automatic model_step();
        bit done_old, pop_old, push_old;
        if (!rst_n) begin
            exp_q.delete();
            m_line.delete();
            m_mode = 0;
            return;
        end
        done_old = (m_mode == 1) && (m_line.size() == 1);
        pop_old  = (exp_q.size() != 0) && !send_break && ((m_mode == 0) || done_old);
        push_old = tx_valid && (exp_q.size() < DEPTH);
        case (m_mode)
            1: begin
                void'(m_line.pop_front());
                if (m_line.size() == 0) m_mode = 0;
            end
            0: if (send_break) begin
                m_mode = 2;
                m_brk_cyc = 1;
                m_brk_baud = eff_baud(int'(baud_div));
            end
            2: if (m_brk_cyc >= m_brk_baud && !send_break) begin
                m_mode = 3;
                m_end_left = m_brk_baud;
            end else begin
                m_brk_cyc++;
            end
            default: begin
                m_end_left--;
                if (m_end_left == 0) m_mode = 0;
            end
        endcase
        if (pop_old) build_frame(exp_q.pop_front());
        if (push_old) exp_q.push_back(tx_data);
    endtask

    always @(posedge clk) begin
        logic exp_tx;
        model_step();
        cyc++;
        #1;
        exp_tx = (m_mode == 1) ? m_line[0] : (m_mode == 2) ? 1'b0 : 1'b1;
        check("cyc_uart_tx", 32'(uart_tx), 32'(exp_tx));
        check("cyc_tx_busy", 32'(tx_busy), 32'(m_mode != 0));
        check("cyc_tx_done", 32'(tx_done), 32'((m_mode == 1) && (m_line.size() == 1)));
        check("cyc_fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("cyc_tx_ready", 32'(tx_ready), 32'(exp_q.size() < DEPTH));
        if (tx_done === 1'b1) done_q.push_back(cyc);
    end

    // Driver tasks: inputs change only on the falling edge.
    task automatic push_word(input logic [DW-1:0] w);
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((tx_busy || fifo_count != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_idle_timeout"}, 32'(guard >= 5000), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_dones(input int target, input string name);
        int guard = 0;
        while (done_q.size() < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_done_timeout"}, 32'(guard >= 5000), 32'd0);
    endtask

    task automatic probe_frame(input logic [DW-1:0] w, input int probe_off,
                               input logic exp_probe, input int exp_done, input string name);
        int t0, base;
        t0 = cyc;
        base = done_q.size();
        push_word(w);
        repeat (probe_off - 1) @(negedge clk);
        check({name, "_probe"}, 32'(uart_tx), 32'(exp_probe));
        wait_dones(base + 1, name);
        if (done_q.size() > base)
            check({name, "_done_at"}, 32'(done_q[base] - t0), 32'(exp_done));
        wait_idle(name);
    endtask

    int bits_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        int t0, base, guard, max_cnt;
        rst_n = 1'b0; baud_div = 16'd4; data_len = 4'd8; parity_mode = 2'd0;
        stop_bits = 1'b0; send_break = 1'b0; tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 at divisor 4, word 0xA5
        t0 = cyc;
        push_word(8'hA5);
        check("t1_busy_c1", 32'(tx_busy), 32'd0);
        check("t1_count_c1", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("t1_start_c2", 32'(uart_tx), 32'd0);
        check("t1_count_c2", 32'(fifo_count), 32'd0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_bit%0d", i), 32'(uart_tx), 32'(bits_a5[i]));
            repeat (4) @(negedge clk);
        end
        check("t1_stop_c39", 32'(uart_tx), 32'd1);
        check("t1_nodone_c39", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_done_c41", 32'(tx_done), 32'd1);
        check("t1_cyc41", 32'(cyc - t0), 32'd41);
        @(negedge clk);
        check("t1_busy_c42", 32'(tx_busy), 32'd0);
        wait_idle("t1");

        // 7 data bits, parity, two stop bits at divisor 3: 33-cycle frame
        baud_div = 16'd3; data_len = 4'd7; stop_bits = 1'b1;
        parity_mode = 2'd1; probe_frame(8'h41, 27, 1'b0, 34, "t2_even");
        parity_mode = 2'd2; probe_frame(8'h41, 27, 1'b1, 34, "t2_odd");
        parity_mode = 2'd3; probe_frame(8'h41, 27, 1'b1, 34, "t2_mark");
        parity_mode = 2'd1; probe_frame(8'hC1, 27, 1'b0, 34, "t2_even_hibit");

        // divisor 0 acts as 2; 5N1 is 7 bits = 14 cycles
        baud_div = 16'd0; data_len = 4'd5; parity_mode = 2'd0; stop_bits = 1'b0;
        probe_frame(8'h1E, 6, 1'b1, 15, "b_div0");
        // out-of-range length acts as 8: bit 7 of 0x80 appears at cycle 18
        baud_div = 16'd2; data_len = 4'd15;
        probe_frame(8'h80, 18, 1'b1, 21, "b_len15");

        // 20 words back-to-back through a 16-deep FIFO
        baud_div = 16'd4; data_len = 4'd8;
        base = done_q.size();
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tx_valid = 1'b1;
            tx_data = 8'(i * 37 + 5);
            guard = 0;
            while (!tx_ready && guard < 2000) begin
                if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                @(negedge clk);
                guard++;
            end
            check("t3_ready_timeout", 32'(guard >= 2000), 32'd0);
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        tx_valid = 1'b0;
        check("t3_max_count", 32'(max_cnt), 32'd16);
        wait_idle("t3");
        check("t3_frames", 32'(done_q.size() - base), 32'd20);

        // config change mid-frame only affects the next frame
        t0 = cyc;
        base = done_q.size();
        push_word(8'h12);
        push_word(8'h34);
        repeat (8) @(negedge clk);
        baud_div = 16'd8; parity_mode = 2'd1;
        wait_dones(base + 2, "t4");
        if (done_q.size() >= base + 2) begin
            check("t4_done1", 32'(done_q[base] - t0), 32'd41);
            check("t4_done2", 32'(done_q[base + 1] - t0), 32'd129);
        end
        wait_idle("t4");

        // break requested mid-frame with two words queued
        baud_div = 16'd4; parity_mode = 2'd0;
        base = done_q.size();
        push_word(8'h55);
        push_word(8'h66);
        push_word(8'h77);
        repeat (7) @(negedge clk);
        send_break = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_break_low", 32'(uart_tx), 32'd0);
        check("t5_break_count", 32'(fifo_count), 32'd2);
        check("t5_break_frames", 32'(done_q.size() - base), 32'd1);
        repeat (20) @(negedge clk);
        send_break = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_break_end_high", 32'(uart_tx), 32'd1);
        check("t5_break_end_busy", 32'(tx_busy), 32'd1);
        wait_idle("t5");
        check("t5_frames", 32'(done_q.size() - base), 32'd3);

        // break and data together at idle: break goes first
        base = done_q.size();
        send_break = 1'b1;
        push_word(8'h99);
        @(negedge clk);
        check("t5b_line", 32'(uart_tx), 32'd0);
        check("t5b_count", 32'(fifo_count), 32'd1);
        repeat (8) @(negedge clk);
        send_break = 1'b0;
        wait_idle("t5b");
        check("t5b_frames", 32'(done_q.size() - base), 32'd1);

        // reset mid-DATA with five words queued
        base = done_q.size();
        for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_line", 32'(uart_tx), 32'd1);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_ready", 32'(tx_ready), 32'd1);
        check("t6_done", 32'(tx_done), 32'd0);
        check("t6_frames", 32'(done_q.size() - base), 32'd0);
        probe_frame(8'h3C, 2, 1'b0, 41, "t6_after");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
